// File: rtl/veripac_pkg.sv
// Shared definitions for the VeriPac work RAM: host register map, STATUS layout
// and the host request bundle seen by the register window.
package veripac_pkg;

  localparam int HOST_W = 8;

  typedef enum logic [1:0] {
    REG_PTR_LO = 2'd0,
    REG_PTR_HI = 2'd1,
    REG_DATA   = 2'd2,
    REG_STATUS = 2'd3
  } reg_sel_e;

  localparam int ST_PFVALID  = 0;
  localparam int ST_COLL_WR  = 1;
  localparam int ST_UNDERRUN = 2;

  typedef struct packed {
    reg_sel_e          sel;
    logic              rd;
    logic              wr;
    logic [HOST_W-1:0] din;
  } host_req_t;

  // coll[0] = host/core write collision, coll[1] = prefetch underrun
  function automatic logic [HOST_W-1:0] status_byte(input logic pf_valid, input logic [1:0] coll);
    logic [HOST_W-1:0] s;
    s              = '0;
    s[ST_PFVALID]  = pf_valid;
    s[ST_COLL_WR]  = coll[0];
    s[ST_UNDERRUN] = coll[1];
    return s;
  endfunction

endpackage

// File: rtl/veripac_dpram_core.sv
// Generic true-dual-port RAM, read-first on every port, registered read data.
// Port 0 takes precedence if both ports write the same word in one cycle.
import veripac_pkg::*;

module veripac_dpram_core #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int INIT_SEQ = 1,
  parameter int NP       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NP-1:0]         en,
  input  logic [NP-1:0]         we,
  input  logic [NP-1:0][AW-1:0] addr,
  input  logic [NP-1:0][DW-1:0] din,
  output logic [NP-1:0][DW-1:0] q
);

  localparam int DEPTH = 1 << AW;

  typedef logic [DEPTH-1:0][DW-1:0] mem_t;

  function automatic mem_t mem_init();
    mem_t m;
    for (int i = 0; i < DEPTH; i++)
      m[i] = (INIT_SEQ != 0) ? DW'(i) : '0;
    return m;
  endfunction

  mem_t mem = mem_init();

  // Walk ports high to low so port 0 lands last and wins an address clash.
  always_ff @(posedge clk) begin
    for (int p = NP - 1; p >= 0; p--)
      if (we[p]) mem[addr[p]] <= din[p];
  end

  // Output registers reset, the array itself does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      for (int p = 0; p < NP; p++)
        if (en[p]) q[p] <= mem[addr[p]];
    end
  end

endmodule

// File: rtl/veripac_dpram.sv
// VeriPac dual-port work RAM: ZX-Uno host register window with auto-increment
// pointer and prefetch buffer on port 0, synchronous CPU port on port 1.
import veripac_pkg::*;

module veripac_dpram #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int INIT_SEQ = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        h_sel,
  input  logic              h_rd,
  input  logic              h_wr,
  input  logic [7:0]        h_din,
  output logic [7:0]        h_dout,
  output logic              h_oe,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic              c_we,
  input  logic [DATA_W-1:0] c_din,
  output logic [DATA_W-1:0] c_dout
);

  localparam int STAGES = 1;

  host_req_t hreq;
  logic [ADDR_W-1:0] ptr, ptr_ld;
  logic [15:0]       ptr16;
  logic [DATA_W-1:0] pf_data;
  logic              pf_valid;
  logic [1:0]        coll;
  logic [STAGES:0]   vld_pipe;   // [0] fetch this cycle, [1] fetched, valid next
  logic hwr, hrd, ptr_wr, data_wr, data_rd, st_wr, fetch_set, coll_hit, core_we;

  logic [1:0]             r_en, r_we;
  logic [1:0][ADDR_W-1:0] r_addr;
  logic [1:0][DATA_W-1:0] r_din, r_q;

  assign hreq.sel = reg_sel_e'(h_sel);
  assign hreq.rd  = h_rd;
  assign hreq.wr  = h_wr;
  assign hreq.din = h_din;

  // A simultaneous read+write is treated as a write only.
  assign hwr       = hreq.wr;
  assign hrd       = hreq.rd & ~hreq.wr;
  assign ptr_wr    = hwr & (hreq.sel == REG_PTR_LO || hreq.sel == REG_PTR_HI);
  assign data_wr   = hwr & (hreq.sel == REG_DATA);
  assign data_rd   = hrd & (hreq.sel == REG_DATA);
  assign st_wr     = hwr & (hreq.sel == REG_STATUS);
  assign fetch_set = ptr_wr | data_wr | data_rd;

  assign coll_hit = data_wr & c_we & (c_addr == ptr);
  assign core_we  = c_we & ~coll_hit;

  assign ptr16 = 16'(ptr);

  generate
    if (ADDR_W > 8) begin : g_ptr_hi
      always_comb begin
        ptr_ld = ptr;
        if (hreq.sel == REG_PTR_LO) ptr_ld[7:0] = hreq.din;
        else                        ptr_ld[ADDR_W-1:8] = hreq.din[ADDR_W-9:0];
      end
    end else begin : g_ptr_lo
      always_comb begin
        ptr_ld = ptr;
        if (hreq.sel == REG_PTR_LO) ptr_ld = hreq.din[ADDR_W-1:0];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     ptr <= '0;
    else if (data_wr || data_rd) ptr <= ptr + ADDR_W'(1);
    else if (ptr_wr)             ptr <= ptr_ld;
  end

  // Reset leaves a fetch pending so the buffer refills from ptr=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= 2'b01;
      pf_valid <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0] & ~fetch_set, fetch_set};
      pf_valid <= ~fetch_set & (pf_valid | vld_pipe[1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coll <= '0;
    end else begin
      coll[0] <= (coll[0] & ~(st_wr & hreq.din[ST_COLL_WR]))  | coll_hit;
      coll[1] <= (coll[1] & ~(st_wr & hreq.din[ST_UNDERRUN])) | (data_rd & ~pf_valid);
    end
  end

  // Port 0 doubles as the prefetch buffer: its output register is pf_data.
  assign r_en   = {1'b1, vld_pipe[0]};
  assign r_we   = {core_we, data_wr};
  assign r_addr = {c_addr, ptr};
  assign r_din  = {c_din, hreq.din[DATA_W-1:0]};

  veripac_dpram_core #(
    .AW       (ADDR_W),
    .DW       (DATA_W),
    .INIT_SEQ (INIT_SEQ),
    .NP       (2)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .en   (r_en),
    .we   (r_we),
    .addr (r_addr),
    .din  (r_din),
    .q    (r_q)
  );

  assign pf_data = r_q[0];
  assign c_dout  = r_q[1];
  assign h_oe    = h_rd;

  always_comb begin
    h_dout = '0;
    if (hrd) begin
      unique case (hreq.sel)
        REG_PTR_LO: h_dout = ptr16[7:0];
        REG_PTR_HI: h_dout = ptr16[15:8];
        REG_DATA:   h_dout = 8'(pf_data);
        REG_STATUS: h_dout = status_byte(pf_valid, coll);
        default:    h_dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_veripac_dpram.sv
// Scoreboard bench for veripac_dpram: an 8-bit-address instance for most checks
// and a 10-bit-address instance for the high pointer byte.
import veripac_pkg::*;

module tb_veripac_dpram;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] h8_sel;  logic h8_rd, h8_wr;  logic [7:0] h8_din, h8_dout;  logic h8_oe;
  logic [7:0] c8_addr; logic c8_we;         logic [7:0] c8_din, c8_dout;
  logic [1:0] h10_sel; logic h10_rd, h10_wr; logic [7:0] h10_din, h10_dout; logic h10_oe;
  logic [9:0] c10_addr; logic c10_we;        logic [7:0] c10_din, c10_dout;
  logic cchk8, cchk10;

  veripac_dpram #(.ADDR_W(8), .DATA_W(8), .INIT_SEQ(1)) dut8 (
    .clk(clk), .rst(rst), .h_sel(h8_sel), .h_rd(h8_rd), .h_wr(h8_wr), .h_din(h8_din),
    .h_dout(h8_dout), .h_oe(h8_oe), .c_addr(c8_addr), .c_we(c8_we), .c_din(c8_din),
    .c_dout(c8_dout));

  veripac_dpram #(.ADDR_W(10), .DATA_W(8), .INIT_SEQ(1)) dut10 (
    .clk(clk), .rst(rst), .h_sel(h10_sel), .h_rd(h10_rd), .h_wr(h10_wr), .h_din(h10_din),
    .h_dout(h10_dout), .h_oe(h10_oe), .c_addr(c10_addr), .c_we(c10_we), .c_din(c10_din),
    .c_dout(c10_dout));

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t q8[$], q10[$], qc8[$], qc10[$];
  int total = 0;
  int bad   = 0;

  // Monitor: whenever a DUT presents read data, pop the next expectation.
  always @(negedge clk) begin
    exp_t e;
    if (h8_oe) begin
      total++;
      if (q8.size() == 0) begin bad++; $display("FAIL h8 unexpected read: got=%02h", h8_dout); end
      else begin
        e = q8.pop_front();
        if (h8_dout !== e.exp) begin bad++; $display("FAIL %s: got=%02h want=%02h", e.name, h8_dout, e.exp); end
      end
    end
    if (h10_oe) begin
      total++;
      if (q10.size() == 0) begin bad++; $display("FAIL h10 unexpected read: got=%02h", h10_dout); end
      else begin
        e = q10.pop_front();
        if (h10_dout !== e.exp) begin bad++; $display("FAIL %s: got=%02h want=%02h", e.name, h10_dout, e.exp); end
      end
    end
    if (cchk8) begin
      total++;
      if (qc8.size() == 0) begin bad++; $display("FAIL c8 unexpected check: got=%02h", c8_dout); end
      else begin
        e = qc8.pop_front();
        if (c8_dout !== e.exp) begin bad++; $display("FAIL %s: got=%02h want=%02h", e.name, c8_dout, e.exp); end
      end
    end
    if (cchk10) begin
      total++;
      if (qc10.size() == 0) begin bad++; $display("FAIL c10 unexpected check: got=%02h", c10_dout); end
      else begin
        e = qc10.pop_front();
        if (c10_dout !== e.exp) begin bad++; $display("FAIL %s: got=%02h want=%02h", e.name, c10_dout, e.exp); end
      end
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic h8(input logic rd, input logic wr, input logic [1:0] sel,
                    input logic [7:0] din, input logic [7:0] exp, input string nm);
    exp_t e;
    h8_sel = sel; h8_rd = rd; h8_wr = wr; h8_din = din;
    if (rd) begin e.name = nm; e.exp = exp; q8.push_back(e); end
    @(posedge clk); #1;
    h8_rd = 1'b0; h8_wr = 1'b0;
  endtask

  task automatic h10(input logic rd, input logic wr, input logic [1:0] sel,
                     input logic [7:0] din, input logic [7:0] exp, input string nm);
    exp_t e;
    h10_sel = sel; h10_rd = rd; h10_wr = wr; h10_din = din;
    if (rd) begin e.name = nm; e.exp = exp; q10.push_back(e); end
    @(posedge clk); #1;
    h10_rd = 1'b0; h10_wr = 1'b0;
  endtask

  // Core access on dut8; c_dout is checked on the cycle after the access.
  task automatic c8(input logic we, input logic [7:0] a, input logic [7:0] d,
                    input logic [7:0] exp, input string nm);
    exp_t e;
    c8_addr = a; c8_we = we; c8_din = d;
    @(posedge clk); #1;
    c8_we = 1'b0;
    e.name = nm; e.exp = exp; qc8.push_back(e);
    cchk8 = 1'b1;
    @(negedge clk); #1;
    cchk8 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    h8_sel = '0; h8_rd = 0; h8_wr = 0; h8_din = '0; c8_addr = '0; c8_we = 0; c8_din = '0;
    h10_sel = '0; h10_rd = 0; h10_wr = 0; h10_din = '0; c10_addr = '0; c10_we = 0; c10_din = '0;
    cchk8 = 0; cchk10 = 0;
    idle(2);

    // reset state, sampled while rst is still high
    e.name = "rst c_dout"; e.exp = 8'h00; qc8.push_back(e);
    cchk8 = 1'b1; @(negedge clk); #1; cchk8 = 1'b0; idle(1);
    h8(1, 0, REG_STATUS, 8'h00, 8'h00, "rst status");
    h8(1, 0, REG_PTR_LO, 8'h00, 8'h00, "rst ptr_lo");
    h8(1, 0, REG_DATA,   8'h00, 8'h00, "rst pf_data");
    rst = 1'b0;
    idle(3);

    // 1: sequential reads of the power-on pattern
    h8(1, 0, REG_STATUS, 8'h00, 8'h01, "t1 status");
    for (int i = 0; i < 4; i++) begin
      h8(1, 0, REG_DATA, 8'h00, 8'(i), "t1 data");
      idle(2);
    end
    h8(1, 0, REG_PTR_LO, 8'h00, 8'h04, "t1 ptr_lo");

    // 2: writes across the top of memory, wrap to 0, read back
    h8(0, 1, REG_PTR_LO, 8'hFE, 8'h00, "");
    h8(0, 1, REG_DATA,   8'hAA, 8'h00, "");
    h8(0, 1, REG_DATA,   8'hBB, 8'h00, "");
    h8(0, 1, REG_DATA,   8'hCC, 8'h00, "");
    h8(1, 0, REG_PTR_LO, 8'h00, 8'h01, "t2 ptr after wrap");
    h8(0, 1, REG_PTR_LO, 8'hFE, 8'h00, "");
    idle(2);
    h8(1, 0, REG_DATA, 8'h00, 8'hAA, "t2 rd FE"); idle(2);
    h8(1, 0, REG_DATA, 8'h00, 8'hBB, "t2 rd FF"); idle(2);
    h8(1, 0, REG_DATA, 8'h00, 8'hCC, "t2 rd 00"); idle(2);
    h8(1, 0, REG_PTR_LO, 8'h00, 8'h01, "t2 ptr final");
    c8(0, 8'h00, 8'h00, 8'hCC, "t2 core rd 00");

    // 3: 10-bit address instance, high pointer byte
    h10(0, 1, REG_PTR_HI, 8'h03, 8'h00, "");
    h10(0, 1, REG_PTR_LO, 8'hFF, 8'h00, "");
    h10(1, 0, REG_PTR_HI, 8'h00, 8'h03, "t3 ptr_hi");
    h10(1, 0, REG_PTR_LO, 8'h00, 8'hFF, "t3 ptr_lo");
    h10(0, 1, REG_DATA,   8'h5A, 8'h00, "");
    c10_addr = 10'h3FF;
    idle(1);
    e.name = "t3 core rd 3FF"; e.exp = 8'h5A; qc10.push_back(e);
    cchk10 = 1'b1; @(negedge clk); #1; cchk10 = 1'b0; idle(1);
    h10(1, 0, REG_PTR_HI, 8'h00, 8'h00, "t3 ptr_hi wrapped");
    h10(1, 0, REG_PTR_LO, 8'h00, 8'h00, "t3 ptr_lo wrapped");

    // 4: same-address collision, host wins; then different addresses
    h8(0, 1, REG_PTR_LO, 8'h10, 8'h00, "");
    c8_addr = 8'h10; c8_din = 8'h22; c8_we = 1'b1;
    h8(0, 1, REG_DATA, 8'h11, 8'h00, "");
    c8_we = 1'b0;
    h8(1, 0, REG_STATUS, 8'h00, 8'h02, "t4 status coll");
    c8(0, 8'h10, 8'h00, 8'h11, "t4 core rd 10");
    h8(0, 1, REG_STATUS, 8'h02, 8'h00, "");
    h8(1, 0, REG_STATUS, 8'h00, 8'h01, "t4 status cleared");
    c8_addr = 8'h40; c8_din = 8'h44; c8_we = 1'b1;
    h8(0, 1, REG_DATA, 8'h33, 8'h00, "");
    c8_we = 1'b0;
    h8(1, 0, REG_STATUS, 8'h00, 8'h00, "t4 status no coll");
    c8(0, 8'h11, 8'h00, 8'h33, "t4 core rd 11");
    c8(0, 8'h40, 8'h00, 8'h44, "t4 core rd 40");

    // 5: back-to-back reads underrun
    h8(0, 1, REG_PTR_LO, 8'h30, 8'h00, "");
    idle(2);
    h8(1, 0, REG_DATA,   8'h00, 8'h30, "t5 rd 30");
    h8(1, 0, REG_DATA,   8'h00, 8'h30, "t5 stale rd");
    h8(1, 0, REG_STATUS, 8'h00, 8'h04, "t5 status underrun");
    h8(1, 0, REG_PTR_LO, 8'h00, 8'h32, "t5 ptr");
    h8(0, 1, REG_STATUS, 8'h04, 8'h00, "");
    idle(2);
    h8(1, 0, REG_STATUS, 8'h00, 8'h01, "t5 status cleared");

    // 6: reset during a prefetch; RAM survives
    h8(0, 1, REG_PTR_LO, 8'h50, 8'h00, "");
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    h8(1, 0, REG_STATUS, 8'h00, 8'h00, "t6 status after rst");
    idle(1);
    h8(1, 0, REG_STATUS, 8'h00, 8'h01, "t6 status refetched");
    h8(1, 0, REG_PTR_LO, 8'h00, 8'h00, "t6 ptr after rst");
    h8(1, 0, REG_DATA,   8'h00, 8'hCC, "t6 rd 00 kept");
    idle(2);
    h8(1, 1, REG_DATA,   8'h99, 8'h00, "t6 rd+wr dout");
    h8(1, 0, REG_PTR_LO, 8'h00, 8'h02, "t6 ptr single inc");
    c8(0, 8'h01, 8'h00, 8'h99, "t6 core rd 01");
    c8(1, 8'h20, 8'h77, 8'h20, "t6 core wr read-first");
    c8(0, 8'h20, 8'h00, 8'h77, "t6 core rd 20");

    idle(2);
    if (q8.size() + q10.size() + qc8.size() + qc10.size() != 0) begin
      total++; bad++;
      $display("FAIL leftover expectations: got=%0d want=0",
               q8.size() + q10.size() + qc8.size() + qc10.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
